pulse_width_monitor: RTL and testbench
======================================

Name: pulse_width_monitor

Overview:
- Receive-side companion to pulse_generator: watches a start strobe and the resulting pulse line.
- Measures, in clk cycles, the start-to-pulse delay and the pulse width.
- Checks both measurements against expected values within a tolerance and reports one result per measurement.
- Sits on the pulse_out net of pulse_generator, giving an in-fabric self-check alongside the bench timing checks.

Parameters:
- CNT_W, 16, width of the internal counter and of the delay/width outputs.
- EXP_DELAY, 3, expected cycles from start rise to pulse rise.
- EXP_WIDTH, 5, expected cycles the pulse is high.
- TOL, 0, allowed absolute deviation in cycles for both checks.
- TIMEOUT_CYCLES, 1000, maximum cycles spent in WAIT_RISE or HIGH before abort; must be below 2^CNT_W-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  synchronous start strobe; the rising edge arms a measurement.
- pulse_in  in  1  synchronous pulse under test.
- busy  out  1  high while a measurement is in progress.
- meas_valid  out  1  one-cycle strobe; result outputs are valid in this cycle.
- delay_cycles  out  CNT_W  measured start-to-rise delay.
- width_cycles  out  CNT_W  measured high time.
- delay_ok  out  1  high when |delay_cycles-EXP_DELAY| <= TOL.
- width_ok  out  1  high when |width_cycles-EXP_WIDTH| <= TOL.
- timeout  out  1  one-cycle strobe on abort.

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-low (reset_n).
- Reset: while reset_n=0, all outputs, counters and edge registers are 0 and the state is IDLE. Deassertion takes effect at the next clk edge.
- Edge detection: start_q and pulse_q hold the previous cycle's values. A rise is detected when the input is 1 and its _q is 0; a fall when the input is 0 and pulse_q is 1. start_q and pulse_q are 0 coming out of reset, so a level already high at reset release counts as a rise.
- States: IDLE, WAIT_RISE, HIGH.
  - IDLE: on a start rise, clear cnt to 0 and go to WAIT_RISE. If pulse_in also rises in that same cycle, go directly to HIGH with delay=0.
  - WAIT_RISE: cnt increments each cycle. On a pulse_in rise, latch delay_cycles=cnt+1, clear cnt, go to HIGH. A pulse_in already high on entry is ignored; only a rising edge counts.
  - HIGH: cnt increments each cycle. On a pulse_in fall, width_cycles=cnt+1, go to IDLE, and assert meas_valid for exactly the next cycle.
  - The arithmetic means a pulse rising N cycles after start yields delay=N, and a pulse high for M cycles yields width=M.
- Result outputs: delay_ok and width_ok are registered together with width_cycles, so all results are valid in the meas_valid cycle. delay_cycles, width_cycles, delay_ok and width_ok hold their values until the next meas_valid or until reset.
- Deviation arithmetic: computed at CNT_W+1 bits, signed, so no wrap occurs.
- busy: 1 in WAIT_RISE and HIGH, 0 in IDLE.
- Timeout: if cnt reaches TIMEOUT_CYCLES in WAIT_RISE or HIGH, go to IDLE and pulse timeout for one cycle. meas_valid is not asserted and the result registers are unchanged.
- Start rise while busy: ignored; the measurement in progress is not restarted.
- Start rise in the same cycle meas_valid is high (state IDLE): accepted, so back-to-back measurements lose no cycle.
- Pulse fall with no prior rise (IDLE or WAIT_RISE): ignored.
- reset_n asserted mid-measurement: immediate abort and everything cleared; no meas_valid or timeout is produced.

Test Plan:
- Reset: reset_n=0 for 10 cycles, then release with no stimulus -> all outputs 0, busy=0 throughout.
- Nominal: start rise at cycle 20, pulse_in high cycles 23-27 -> meas_valid one cycle after the fall; delay_cycles=3, width_cycles=5, delay_ok=1, width_ok=1.
- Out of tolerance (TOL=0): pulse high 6 cycles starting 4 cycles after start -> delay_cycles=4, width_cycles=6, delay_ok=0, width_ok=0. Repeat with TOL=1 -> both ok=1.
- Same-cycle start and pulse rise: start and pulse_in rise together, pulse held 2 cycles -> delay_cycles=0, width_cycles=2.
- Timeout (TIMEOUT_CYCLES=50): start rise with pulse_in held 0 -> timeout pulse 50 cycles later, busy drops, meas_valid never asserted, previous results retained.
- Second start while busy / reset mid-measurement:
  - Second start 1 cycle after the first -> measurement unaffected.
  - reset_n pulsed low while in HIGH -> all outputs 0, no meas_valid; the next start measures correctly.

Source files
------------

// File: rtl/pulse_width_monitor.sv
// pulse_width_monitor: measures the start-to-pulse delay and the pulse width in
// clk cycles, and checks each measurement against an expected value within TOL.
module pulse_width_monitor #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned EXP_DELAY      = 3,
    parameter int unsigned EXP_WIDTH      = 5,
    parameter int unsigned TOL            = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pulse_in,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] delay_cycles,
    output logic [CNT_W-1:0] width_cycles,
    output logic             delay_ok,
    output logic             width_ok,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LP_EXP_DELAY = CNT_W'(EXP_DELAY);
    localparam logic [CNT_W-1:0] LP_EXP_WIDTH = CNT_W'(EXP_WIDTH);
    localparam logic [CNT_W-1:0] LP_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0]   LP_TOL       = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_start_q;
    logic             r_pulse_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_delay_meas;
    logic             r_busy;
    logic             r_meas_valid;
    logic [CNT_W-1:0] r_delay_cycles;
    logic [CNT_W-1:0] r_width_cycles;
    logic             r_delay_ok;
    logic             r_width_ok;
    logic             r_timeout;

    logic             w_start_rise;
    logic             w_pulse_rise;
    logic             w_pulse_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    // Edge detection against the previous-cycle samples, plus the counter step.
    always_comb begin
        w_start_rise = start & ~r_start_q;
        w_pulse_rise = pulse_in & ~r_pulse_q;
        w_pulse_fall = ~pulse_in & r_pulse_q;
        w_cnt_inc    = r_cnt + CNT_W'(1);
    end

    // Absolute deviation at CNT_W+1 signed bits so the subtraction cannot wrap.
    function automatic logic f_in_tol(input logic [CNT_W-1:0] i_val,
                                      input logic [CNT_W-1:0] i_exp);
        logic signed [CNT_W:0] w_dev;
        w_dev = $signed({1'b0, i_val}) - $signed({1'b0, i_exp});
        if (w_dev < 0) begin
            w_dev = -w_dev;
        end
        return ($unsigned(w_dev) <= LP_TOL);
    endfunction

    // Measurement FSM: arm on start rise, time the delay, time the width, report.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_start_q      <= 1'b0;
            r_pulse_q      <= 1'b0;
            r_cnt          <= '0;
            r_delay_meas   <= '0;
            r_busy         <= 1'b0;
            r_meas_valid   <= 1'b0;
            r_delay_cycles <= '0;
            r_width_cycles <= '0;
            r_delay_ok     <= 1'b0;
            r_width_ok     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_start_q    <= start;
            r_pulse_q    <= pulse_in;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (w_pulse_rise) begin
                            r_delay_meas <= '0;
                            r_state      <= ST_HIGH;
                        end else begin
                            r_state      <= ST_WAIT_RISE;
                        end
                    end
                end
                ST_WAIT_RISE: begin
                    if (w_pulse_rise) begin
                        r_delay_meas <= w_cnt_inc;
                        r_cnt        <= '0;
                        r_state      <= ST_HIGH;
                    end else if (w_cnt_inc == LP_TIMEOUT) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HIGH: begin
                    if (w_pulse_fall) begin
                        r_delay_cycles <= r_delay_meas;
                        r_width_cycles <= w_cnt_inc;
                        r_delay_ok     <= f_in_tol(r_delay_meas, LP_EXP_DELAY);
                        r_width_ok     <= f_in_tol(w_cnt_inc, LP_EXP_WIDTH);
                        r_meas_valid   <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (w_cnt_inc == LP_TIMEOUT) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output drive straight from registers.
    always_comb begin
        busy         = r_busy;
        meas_valid   = r_meas_valid;
        delay_cycles = r_delay_cycles;
        width_cycles = r_width_cycles;
        delay_ok     = r_delay_ok;
        width_ok     = r_width_ok;
        timeout      = r_timeout;
    end

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Directed bench for pulse_width_monitor: dut A uses TOL=0, dut B uses TOL=1,
// both with TIMEOUT_CYCLES=50 and driven by the same start/pulse stimulus.
module tb_pulse_width_monitor;

    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic pulse_in;

    logic             a_busy, a_meas_valid, a_delay_ok, a_width_ok, a_timeout;
    logic [CNT_W-1:0] a_delay_cycles, a_width_cycles;
    logic             b_busy, b_meas_valid, b_delay_ok, b_width_ok, b_timeout;
    logic [CNT_W-1:0] b_delay_cycles, b_width_cycles;

    int checks   = 0;
    int failures = 0;
    int mv_count = 0;

    always #5 clk = ~clk;

    pulse_width_monitor #(
        .CNT_W(CNT_W), .EXP_DELAY(3), .EXP_WIDTH(5), .TOL(0), .TIMEOUT_CYCLES(50)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .pulse_in(pulse_in),
        .busy(a_busy), .meas_valid(a_meas_valid),
        .delay_cycles(a_delay_cycles), .width_cycles(a_width_cycles),
        .delay_ok(a_delay_ok), .width_ok(a_width_ok), .timeout(a_timeout)
    );

    pulse_width_monitor #(
        .CNT_W(CNT_W), .EXP_DELAY(3), .EXP_WIDTH(5), .TOL(1), .TIMEOUT_CYCLES(50)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .pulse_in(pulse_in),
        .busy(b_busy), .meas_valid(b_meas_valid),
        .delay_cycles(b_delay_cycles), .width_cycles(b_width_cycles),
        .delay_ok(b_delay_ok), .width_ok(b_width_ok), .timeout(b_timeout)
    );

    // Count meas_valid strobes of dut A away from the active edge.
    always @(negedge clk) begin
        if (a_meas_valid === 1'b1) mv_count++;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start rise, pulse rise d cycles later, pulse high w cycles; ends in the
    // meas_valid cycle with start and pulse_in low.
    task automatic measure(input string tag, input int d, input int w,
                           input int exp_d, input int exp_w,
                           input logic a_dok, input logic a_wok,
                           input logic b_dok, input logic b_wok);
        start = 1'b1;
        if (d == 0) pulse_in = 1'b1;
        step();
        chk({tag, "_busy_armed"}, 32'(a_busy), 32'd1);
        start = 1'b0;
        if (d > 0) begin
            repeat (d - 1) step();
            pulse_in = 1'b1;
            step();
        end
        repeat (w - 1) step();
        chk({tag, "_mv_before_fall"}, 32'(a_meas_valid), 32'd0);
        pulse_in = 1'b0;
        step();
        chk({tag, "_mv"},      32'(a_meas_valid),   32'd1);
        chk({tag, "_busy"},    32'(a_busy),         32'd0);
        chk({tag, "_delay"},   32'(a_delay_cycles), 32'(exp_d));
        chk({tag, "_width"},   32'(a_width_cycles), 32'(exp_w));
        chk({tag, "_dok_a"},   32'(a_delay_ok),     32'(a_dok));
        chk({tag, "_wok_a"},   32'(a_width_ok),     32'(a_wok));
        chk({tag, "_delay_b"}, 32'(b_delay_cycles), 32'(exp_d));
        chk({tag, "_dok_b"},   32'(b_delay_ok),     32'(b_dok));
        chk({tag, "_wok_b"},   32'(b_width_ok),     32'(b_wok));
    endtask

    initial begin
        int mv_snap;
        reset_n  = 1'b0;
        start    = 1'b0;
        pulse_in = 1'b0;

        // Reset held for 10 cycles, busy low throughout.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_busy", 32'(a_busy), 32'd0);
        end
        chk("rst_mv",    32'(a_meas_valid),   32'd0);
        chk("rst_delay", 32'(a_delay_cycles), 32'd0);
        chk("rst_width", 32'(a_width_cycles), 32'd0);
        chk("rst_dok",   32'(a_delay_ok),     32'd0);
        chk("rst_wok",   32'(a_width_ok),     32'd0);
        chk("rst_to",    32'(a_timeout),      32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("idle_busy", 32'(a_busy), 32'd0);
        end
        chk("idle_mv", 32'(a_meas_valid), 32'd0);

        // Nominal, then back-to-back start in the meas_valid cycle.
        measure("nom", 3, 5, 3, 5, 1'b1, 1'b1, 1'b1, 1'b1);
        measure("oot", 4, 6, 4, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("oot_mv_drop", 32'(a_meas_valid), 32'd1);
        step();
        chk("oot_mv_once", 32'(a_meas_valid), 32'd0);
        chk("oot_hold",    32'(a_width_cycles), 32'd6);

        // Start and pulse rise in the same cycle.
        measure("same", 0, 2, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Timeout: no pulse, abort 50 cycles after the start edge.
        mv_snap = mv_count;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (49) step();
        chk("to_busy_before", 32'(a_busy),    32'd1);
        chk("to_pre",         32'(a_timeout), 32'd0);
        step();
        chk("to_strobe",  32'(a_timeout), 32'd1);
        chk("to_busy",    32'(a_busy),    32'd0);
        chk("to_b_strobe", 32'(b_timeout), 32'd1);
        step();
        chk("to_once",    32'(a_timeout),      32'd0);
        chk("to_no_mv",   32'(mv_count),       32'(mv_snap));
        chk("to_keep_w",  32'(a_width_cycles), 32'd2);
        chk("to_keep_d",  32'(a_delay_cycles), 32'd0);

        // Second start rise while busy is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("restart_busy", 32'(a_busy), 32'd1);
        start    = 1'b0;
        pulse_in = 1'b1;
        step();
        repeat (4) step();
        pulse_in = 1'b0;
        step();
        chk("restart_mv",    32'(a_meas_valid),   32'd1);
        chk("restart_delay", 32'(a_delay_cycles), 32'd3);
        chk("restart_width", 32'(a_width_cycles), 32'd5);
        chk("restart_ok",    32'(a_delay_ok & a_width_ok), 32'd1);
        step();

        // Reset asserted while in HIGH clears everything immediately.
        mv_snap = mv_count;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        pulse_in = 1'b1;
        step();
        step();
        chk("mid_busy", 32'(a_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(a_busy),         32'd0);
        chk("mid_rst_delay", 32'(a_delay_cycles), 32'd0);
        chk("mid_rst_width", 32'(a_width_cycles), 32'd0);
        chk("mid_rst_ok",    32'(a_delay_ok | a_width_ok), 32'd0);
        pulse_in = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("mid_no_mv", 32'(mv_count),  32'(mv_snap));
        chk("mid_no_to", 32'(a_timeout), 32'd0);

        measure("post", 3, 5, 3, 5, 1'b1, 1'b1, 1'b1, 1'b1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
